// File: rtl/riscv_gpio_mmio_if.sv
// Data-bus view of the GPIO peripheral: byte address, write data/strobe, read data.
// Read data is combinational from the address, and writes take effect on the clock edge.
// No backpressure; the slave accepts one access per cycle with no wait states.
interface riscv_gpio_mmio_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  we;
  logic [31:0]           rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/riscv_gpio_mmio.sv
// Memory-mapped GPIO: output reg with set/clear, synchronised inputs, edge-detect W1C status, level irq.
// Reads are zero-latency combinational, writes land on the strobed edge, and input-to-IN takes SYNC_STAGES edges.
// No backpressure; every bus access completes in the cycle it is presented.
module riscv_gpio_mmio #(
  parameter int                    WIDTH       = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_gpio_mmio_if.slave       bus,
  input  logic [WIDTH-1:0]       gpio_port_in,
  output logic [WIDTH-1:0]       gpio_port_out,
  output logic                   irq
);

  localparam logic [2:0] OFF_OUT      = 3'd0;
  localparam logic [2:0] OFF_IN       = 3'd1;
  localparam logic [2:0] OFF_EDGE_EN  = 3'd2;
  localparam logic [2:0] OFF_EDGE_POL = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_OUT_SET  = 3'd5;
  localparam logic [2:0] OFF_OUT_CLR  = 3'd6;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] in_prev_q, in_prev_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] edge_en_q, edge_en_d;
  logic [WIDTH-1:0] edge_pol_q, edge_pol_d;
  logic [WIDTH-1:0] status_q, status_d;

  logic             sel;
  logic [2:0]       off;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise, fall, evt;
  logic [31:0]      rdata_w;

  // Low address bits and any wdata above WIDTH are don't-cares for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  assign sel     = (bus.addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign off     = bus.addr[4:2];
  assign wr      = bus.we & sel;
  assign wd      = bus.wdata[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];

  // Edge detect on the synchronised input; polarity picks rise or fall per bit.
  always_comb begin
    rise = in_sync & ~in_prev_q;
    fall = ~in_sync & in_prev_q;
    evt  = edge_en_q & ((edge_pol_q & rise) | (~edge_pol_q & fall));
  end

  // Next-state: synchroniser shift, register writes, and W1C status where a new event beats a clear.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], gpio_port_in};
    in_prev_d  = in_sync;
    out_d      = out_q;
    edge_en_d  = edge_en_q;
    edge_pol_d = edge_pol_q;
    status_d   = (status_q & ~((wr && off == OFF_STATUS) ? wd : '0)) | evt;
    if (wr) begin
      case (off)
        OFF_OUT:      out_d      = wd;
        OFF_EDGE_EN:  edge_en_d  = wd;
        OFF_EDGE_POL: edge_pol_d = wd;
        OFF_OUT_SET:  out_d      = out_q | wd;
        OFF_OUT_CLR:  out_d      = out_q & ~wd;
        default:      ;
      endcase
    end
  end

  // State registers; everything clears asynchronously so outputs are quiet during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      in_prev_q  <= '0;
      out_q      <= '0;
      edge_en_q  <= '0;
      edge_pol_q <= '0;
      status_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      in_prev_q  <= in_prev_d;
      out_q      <= out_d;
      edge_en_q  <= edge_en_d;
      edge_pol_q <= edge_pol_d;
      status_q   <= status_d;
    end
  end

  // Read mux: side-effect free, zero-extended, write-only and reserved slots read as zero.
  always_comb begin
    rdata_w = '0;
    if (sel) begin
      case (off)
        OFF_OUT:      rdata_w[WIDTH-1:0] = out_q;
        OFF_IN:       rdata_w[WIDTH-1:0] = in_sync;
        OFF_EDGE_EN:  rdata_w[WIDTH-1:0] = edge_en_q;
        OFF_EDGE_POL: rdata_w[WIDTH-1:0] = edge_pol_q;
        OFF_STATUS:   rdata_w[WIDTH-1:0] = status_q;
        default:      rdata_w = '0;
      endcase
    end
  end

  assign bus.rdata     = rdata_w;
  assign gpio_port_out = out_q;
  assign irq           = |status_q;

endmodule

// File: tb/tb_riscv_gpio_mmio.sv
// Directed bench for riscv_gpio_mmio: an 8-bit instance for function, a 12-bit one for width.
// Inputs are driven 1ns after the rising edge and outputs are sampled before the next edge.
// The bus has no backpressure, so each write occupies exactly one strobed edge.
module tb_riscv_gpio_mmio;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rst;
  logic [7:0]  gpio_in8;
  logic [7:0]  gpio_out8;
  logic        irq8;
  logic [11:0] gpio_in12;
  logic [11:0] gpio_out12;
  logic        irq12;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;

  riscv_gpio_mmio_if #(.ADDR_WIDTH(32)) bus8 ();
  riscv_gpio_mmio_if #(.ADDR_WIDTH(32)) bus12 ();

  riscv_gpio_mmio #(.WIDTH(8), .SYNC_STAGES(2), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .bus(bus8),
    .gpio_port_in(gpio_in8), .gpio_port_out(gpio_out8), .irq(irq8)
  );

  riscv_gpio_mmio #(.WIDTH(12), .SYNC_STAGES(2), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) u_dut12 (
    .clk(clk), .rst(rst), .bus(bus12),
    .gpio_port_in(gpio_in12), .gpio_port_out(gpio_out12), .irq(irq12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [31:0] a, input logic [31:0] d);
    bus8.addr  = a;
    bus8.wdata = d;
    bus8.we    = 1'b1;
    @(posedge clk);
    #1;
    bus8.we    = 1'b0;
  endtask

  task automatic rd8(input logic [31:0] a, output logic [31:0] d);
    bus8.addr = a;
    #1;
    d = bus8.rdata;
  endtask

  task automatic wr12(input logic [31:0] a, input logic [31:0] d);
    bus12.addr  = a;
    bus12.wdata = d;
    bus12.we    = 1'b1;
    @(posedge clk);
    #1;
    bus12.we    = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    gpio_in8    = 8'h03;
    gpio_in12   = 12'h000;
    bus8.addr   = BASE;
    bus8.wdata  = '0;
    bus8.we     = 1'b0;
    bus12.addr  = BASE;
    bus12.wdata = '0;
    bus12.we    = 1'b0;

    // Reset held with inputs high: outputs quiet, IN still zero.
    tick(2);
    chk("rst_out", {24'h0, gpio_out8}, 32'h0);
    chk("rst_irq", {31'h0, irq8}, 32'h0);
    rd8(BASE + 32'h04, rv);
    chk("rst_in", rv, 32'h0);

    // Release: IN follows the pins after two edges.
    rst = 1'b1;
    tick(1);
    rd8(BASE + 32'h04, rv);
    chk("in_1edge", rv, 32'h0);
    tick(1);
    rd8(BASE + 32'h04, rv);
    chk("in_2edge", rv, 32'h3);

    gpio_in8 = 8'h00;
    tick(4);

    // OUT with atomic set / clear.
    wr8(BASE + 32'h00, 32'hA5);
    chk("out_wr", {24'h0, gpio_out8}, 32'hA5);
    wr8(BASE + 32'h14, 32'h0A);
    chk("out_set", {24'h0, gpio_out8}, 32'hAF);
    wr8(BASE + 32'h18, 32'h81);
    chk("out_clr", {24'h0, gpio_out8}, 32'h2E);
    rd8(BASE + 32'h00, rv);
    chk("out_rd", rv, 32'h2E);
    rd8(BASE + 32'h14, rv);
    chk("set_rd0", rv, 32'h0);
    rd8(BASE + 32'h18, rv);
    chk("clr_rd0", rv, 32'h0);

    // Rising edge on bit0: STATUS and irq exactly three edges after the pin change.
    wr8(BASE + 32'h08, 32'h01);
    wr8(BASE + 32'h0C, 32'h01);
    rd8(BASE + 32'h08, rv);
    chk("en_rd", rv, 32'h01);
    gpio_in8 = 8'h01;
    tick(2);
    rd8(BASE + 32'h10, rv);
    chk("rise_e2_stat", rv, 32'h0);
    chk("rise_e2_irq", {31'h0, irq8}, 32'h0);
    tick(1);
    rd8(BASE + 32'h10, rv);
    chk("rise_e3_stat", rv, 32'h1);
    chk("rise_e3_irq", {31'h0, irq8}, 32'h1);
    rd8(BASE + 32'h10, rv);
    chk("stat_read_noclr", rv, 32'h1);
    wr8(BASE + 32'h10, 32'h01);
    rd8(BASE + 32'h10, rv);
    chk("w1c_stat", rv, 32'h0);
    chk("w1c_irq", {31'h0, irq8}, 32'h0);

    // Falling edge on bit2 only; bit3 toggles but is masked.
    wr8(BASE + 32'h08, 32'h04);
    wr8(BASE + 32'h0C, 32'h00);
    gpio_in8 = 8'h0D;
    tick(4);
    rd8(BASE + 32'h10, rv);
    chk("fall_rise_none", rv, 32'h0);
    gpio_in8 = 8'h01;
    tick(2);
    rd8(BASE + 32'h10, rv);
    chk("fall_e2", rv, 32'h0);
    tick(1);
    rd8(BASE + 32'h10, rv);
    chk("fall_e3", rv, 32'h4);
    chk("fall_irq", {31'h0, irq8}, 32'h1);
    wr8(BASE + 32'h08, 32'h00);
    rd8(BASE + 32'h10, rv);
    chk("en_off_keeps", rv, 32'h4);
    wr8(BASE + 32'h10, 32'h04);
    rd8(BASE + 32'h10, rv);
    chk("fall_clr", rv, 32'h0);

    // Enabling a steady-high pin makes no event.
    wr8(BASE + 32'h0C, 32'h01);
    wr8(BASE + 32'h08, 32'h01);
    tick(3);
    rd8(BASE + 32'h10, rv);
    chk("steady_high", rv, 32'h0);

    // Collision: W1C on the same edge the new rising event is registered.
    gpio_in8 = 8'h00;
    tick(4);
    gpio_in8 = 8'h01;
    tick(2);
    wr8(BASE + 32'h10, 32'h01);
    rd8(BASE + 32'h10, rv);
    chk("collide_set_wins", rv, 32'h1);
    wr8(BASE + 32'h10, 32'h01);
    rd8(BASE + 32'h10, rv);
    chk("collide_then_clr", rv, 32'h0);

    // Decode: reserved slot and out-of-window addresses do nothing and read zero.
    wr8(BASE + 32'h1C, 32'hFF);
    wr8(BASE + 32'h20, 32'hFF);
    wr8(BASE + 32'h28, 32'hFF);
    wr8(32'h2001_0000, 32'hFF);
    chk("dec_out", {24'h0, gpio_out8}, 32'h2E);
    rd8(BASE + 32'h08, rv);
    chk("dec_en", rv, 32'h01);
    rd8(BASE + 32'h1C, rv);
    chk("dec_rsv_rd", rv, 32'h0);
    rd8(BASE + 32'h20, rv);
    chk("dec_oow_rd", rv, 32'h0);
    rd8(BASE + 32'h03, rv);
    chk("dec_lowbits", rv, 32'h2E);

    // Width: 12-bit instance truncates writes and zero-extends reads.
    wr12(BASE + 32'h00, 32'hFFFF_FFFF);
    bus12.addr = BASE + 32'h00;
    #1;
    chk("w12_rd", bus12.rdata, 32'h0000_0FFF);
    chk("w12_pins", {20'h0, gpio_out12}, 32'h0000_0FFF);
    wr12(BASE + 32'h18, 32'h0000_0F0F);
    bus12.addr = BASE + 32'h00;
    #1;
    chk("w12_clr", bus12.rdata, 32'h0000_00F0);
    chk("w12_irq", {31'h0, irq12}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
